// File: rtl/hk_usb_pkg.sv
// Shared definitions for the MAX3421E register-protocol SPI responder.
package hk_usb_pkg;

    localparam int          ADDR_W      = 5;
    localparam logic [4:0]  REG_RCVFIFO = 5'd1;
    localparam logic [4:0]  REG_SNDFIFO = 5'd2;
    localparam logic [4:0]  REG_HIRQ    = 5'd25;
    localparam logic [4:0]  REG_HIEN    = 5'd26;

    // Frame phases: waiting for select, command byte, data bytes out/in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes the asynchronous SPI pins into clk and derives edge strobes.
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic mosi,
    input  logic ss_n,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_fall,
    output logic ss_rise,
    output logic ss_n_sync,
    output logic mosi_sync
);

    logic [STAGES-1:0] sclk_sr;
    logic [STAGES-1:0] mosi_sr;
    logic [STAGES-1:0] ss_sr;
    logic              sclk_prev;
    logic              ss_prev;

    // Synchronizer chains plus one history flop per clock-like pin; ss_n idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sr   <= '0;
            mosi_sr   <= '0;
            ss_sr     <= '1;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b1;
        end else begin
            sclk_sr   <= {sclk_sr[STAGES-2:0], sclk};
            mosi_sr   <= {mosi_sr[STAGES-2:0], mosi};
            ss_sr     <= {ss_sr[STAGES-2:0], ss_n};
            sclk_prev <= sclk_sr[STAGES-1];
            ss_prev   <= ss_sr[STAGES-1];
        end
    end

    // mosi and sclk go through equal-length chains, so mosi_sync is aligned with sclk_rise.
    assign sclk_rise = sclk_sr[STAGES-1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sr[STAGES-1] & sclk_prev;
    assign ss_fall   = ~ss_sr[STAGES-1] & ss_prev;
    assign ss_rise   = ss_sr[STAGES-1] & ~ss_prev;
    assign ss_n_sync = ss_sr[STAGES-1];
    assign mosi_sync = mosi_sr[STAGES-1];

endmodule

// File: rtl/max3421_spi_responder.sv
// SPI mode-0 slave speaking the MAX3421E register protocol over a 32x8 register file.
// Frame: command byte {addr[4:0], x, dir, x} then data bytes to/from the same address.
// The first byte shifted out of every frame is the HIRQ status register.
module max3421_spi_responder
    import hk_usb_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         NUM_REGS    = 32,
    parameter logic [4:0] HIRQ_ADDR   = REG_HIRQ,
    parameter logic [4:0] HIEN_ADDR   = REG_HIEN
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_ss_n,
    output logic       spi_miso,
    output logic       irq_n,
    input  logic       loc_we,
    input  logic [4:0] loc_addr,
    input  logic [7:0] loc_wdata,
    output logic [7:0] loc_rdata,
    input  logic [7:0] loc_irq_set,
    output logic       spi_wr_valid,
    output logic [4:0] spi_wr_addr,
    output logic [7:0] spi_wr_data,
    output spi_state_e fsm_state
);

    logic       sclk_rise;
    logic       sclk_fall;
    logic       ss_fall;
    logic       ss_rise;
    logic       ss_n_sync;
    logic       mosi_sync;

    spi_state_e state;
    spi_state_e state_next;
    logic [2:0] bit_cnt;
    logic [7:0] shift_in;
    logic [7:0] shift_out;
    logic [4:0] addr_q;
    logic [7:0] byte_now;
    logic       byte_done;
    logic       spi_commit;
    logic [4:0] load_addr;

    logic [7:0] regs      [NUM_REGS];
    logic [7:0] regs_next [NUM_REGS];

    spi_pin_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .sclk      (spi_sclk),
        .mosi      (spi_mosi),
        .ss_n      (spi_ss_n),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_fall   (ss_fall),
        .ss_rise   (ss_rise),
        .ss_n_sync (ss_n_sync),
        .mosi_sync (mosi_sync)
    );

    // The byte as it stands including the bit being sampled on this rise.
    assign byte_now   = {shift_in[6:0], mosi_sync};
    // A deselect on the same cycle as the 8th rise aborts the byte.
    assign byte_done  = sclk_rise && (bit_cnt == 3'd7) && (state != IDLE) && !ss_rise;
    assign spi_commit = byte_done && (state == WDATA);
    // At the end of the command byte the address comes straight from the byte itself.
    assign load_addr  = (state == CMD) ? byte_now[7:3] : addr_q;
    assign fsm_state  = state;

    // FSM state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: select opens a frame, the command byte picks direction, deselect ends it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ss_fall) state_next = CMD;
            end
            CMD: begin
                if (ss_rise)        state_next = IDLE;
                else if (byte_done) state_next = byte_now[1] ? WDATA : RDATA;
            end
            WDATA, RDATA: begin
                if (ss_rise) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit counter, shift registers and latched frame address.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bit_cnt   <= 3'd0;
            shift_in  <= 8'd0;
            shift_out <= 8'd0;
            addr_q    <= 5'd0;
        end else if (ss_rise) begin
            bit_cnt <= 3'd0;
        end else if (ss_fall && state == IDLE) begin
            bit_cnt   <= 3'd0;
            shift_out <= regs[HIRQ_ADDR];
        end else if (sclk_rise && state != IDLE) begin
            bit_cnt  <= bit_cnt + 3'd1;
            shift_in <= byte_now;
            if (bit_cnt == 3'd7) begin
                // Next byte out is always the addressed register; re-reads see fresh data.
                shift_out <= regs[load_addr];
                if (state == CMD) addr_q <= byte_now[7:3];
            end else begin
                shift_out <= {shift_out[6:0], 1'b0};
            end
        end
    end

    // MISO: quiet when deselected, status MSB on select, next bit on each falling sclk.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            spi_miso <= 1'b0;
        end else if (ss_n_sync) begin
            spi_miso <= 1'b0;
        end else if (ss_fall) begin
            spi_miso <= regs[HIRQ_ADDR][7];
        end else if (sclk_fall && state != IDLE) begin
            spi_miso <= shift_out[7];
        end
    end

    // Register file next value: local write, then SPI commit overriding it, then irq sets on top.
    always_comb begin
        regs_next = regs;
        if (loc_we) regs_next[loc_addr] = loc_wdata;
        if (spi_commit) begin
            if (addr_q == HIRQ_ADDR) regs_next[addr_q] = regs[HIRQ_ADDR] & ~byte_now;
            else                     regs_next[addr_q] = byte_now;
        end
        regs_next[HIRQ_ADDR] = regs_next[HIRQ_ADDR] | loc_irq_set;
    end

    // Register file storage.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'd0;
        end else begin
            regs <= regs_next;
        end
    end

    // Registered side outputs: commit notification, local readback, interrupt line.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            spi_wr_valid <= 1'b0;
            spi_wr_addr  <= 5'd0;
            spi_wr_data  <= 8'd0;
            loc_rdata    <= 8'd0;
            irq_n        <= 1'b1;
        end else begin
            spi_wr_valid <= spi_commit;
            if (spi_commit) begin
                spi_wr_addr <= addr_q;
                spi_wr_data <= byte_now;
            end
            loc_rdata <= regs[loc_addr];
            irq_n     <= ~|(regs[HIRQ_ADDR] & regs[HIEN_ADDR]);
        end
    end

endmodule

// File: tb/tb_max3421_spi_responder.sv
// Bench for max3421_spi_responder: directed protocol scenarios followed by random frames,
// checked against a register-array model of the MAX3421E register protocol.
module tb_max3421_spi_responder;
    import hk_usb_pkg::*;

    localparam int H = 8;   // sclk half period in clk cycles

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_ss_n;
    logic       spi_miso;
    logic       irq_n;
    logic       loc_we;
    logic [4:0] loc_addr;
    logic [7:0] loc_wdata;
    logic [7:0] loc_rdata;
    logic [7:0] loc_irq_set;
    logic       spi_wr_valid;
    logic [4:0] spi_wr_addr;
    logic [7:0] spi_wr_data;
    spi_state_e fsm_state;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  model [32];
    logic [12:0] exp_q [$];
    logic [12:0] obs_q [$];
    logic [7:0]  tx_q  [$];
    logic [7:0]  rx_q  [$];

    max3421_spi_responder dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .spi_sclk      (spi_sclk),
        .spi_mosi      (spi_mosi),
        .spi_ss_n      (spi_ss_n),
        .spi_miso      (spi_miso),
        .irq_n         (irq_n),
        .loc_we        (loc_we),
        .loc_addr      (loc_addr),
        .loc_wdata     (loc_wdata),
        .loc_rdata     (loc_rdata),
        .loc_irq_set   (loc_irq_set),
        .spi_wr_valid  (spi_wr_valid),
        .spi_wr_addr   (spi_wr_addr),
        .spi_wr_data   (spi_wr_data),
        .fsm_state     (fsm_state)
    );

    // Clock.
    always #5 clk_clk = ~clk_clk;

    // Commit monitor, sampled away from the active edge.
    always @(negedge clk_clk) begin
        if (reset_reset_n === 1'b1 && spi_wr_valid === 1'b1)
            obs_q.push_back({spi_wr_addr, spi_wr_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    function automatic logic [31:0] irq_expect();
        return 32'(~|(model[REG_HIRQ] & model[REG_HIEN]));
    endfunction

    task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
        loc_we = 1'b1; loc_addr = a; loc_wdata = d;
        tick(1);
        loc_we = 1'b0;
        model[a] = d;
    endtask

    task automatic loc_check(input string tag, input logic [4:0] a);
        loc_addr = a;
        tick(1);
        check(tag, 32'(loc_rdata), 32'(model[a]));
    endtask

    task automatic irq_pulse(input logic [7:0] m);
        loc_irq_set = m;
        tick(1);
        loc_irq_set = 8'h00;
        model[REG_HIRQ] = model[REG_HIRQ] | m;
    endtask

    // Shift n bits MSB first; a nonzero set_mask is held on loc_irq_set up to the commit edge of bit 8.
    task automatic spi_bits(input logic [7:0] v, input int n, input logic [7:0] set_mask,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 0; b < n; b++) begin
            spi_mosi = v[7-b];
            tick(H);
            rx = {rx[6:0], spi_miso};
            if (b == 7 && set_mask != 8'h00) begin
                int k;
                loc_irq_set = set_mask;
                spi_sclk = 1'b1;
                k = 0;
                tick(1);
                while (spi_wr_valid !== 1'b1 && k < 2*H) begin
                    tick(1);
                    k++;
                end
                loc_irq_set = 8'h00;
                check("collide_commit_seen", 32'(spi_wr_valid), 32'd1);
                tick(H);
            end else begin
                spi_sclk = 1'b1;
                tick(H);
            end
            spi_sclk = 1'b0;
        end
    endtask

    task automatic compare_commits();
        check("commit_count", 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check("commit_addr_data", 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        obs_q.delete();
        exp_q.delete();
    endtask

    // Full frame: command then nbytes from tx_q; model predicts MISO bytes and commits.
    task automatic spi_frame(input logic [7:0] cmd, input int nbytes, input logic [7:0] set_mask);
        logic [7:0] r;
        logic [7:0] d;
        logic [7:0] m;
        logic [4:0] a;
        a = cmd[7:3];
        rx_q.delete();
        spi_ss_n = 1'b0;
        tick(H);
        spi_bits(cmd, 8, 8'h00, r);
        rx_q.push_back(r);
        check("cmd_miso_hirq", 32'(r), 32'(model[REG_HIRQ]));
        for (int i = 0; i < nbytes; i++) begin
            d = tx_q[i];
            m = (i == nbytes - 1) ? set_mask : 8'h00;
            spi_bits(d, 8, m, r);
            rx_q.push_back(r);
            if (cmd[1]) begin
                exp_q.push_back({a, d});
                if (a == REG_HIRQ) model[a] = (model[a] & ~d) | m;
                else               model[a] = d;
            end else begin
                check("read_miso", 32'(r), 32'(model[a]));
            end
        end
        tick(H);
        spi_ss_n = 1'b1;
        tick(2*H);
        tx_q.delete();
        compare_commits();
        check("frame_end_idle", 32'(fsm_state), 32'(IDLE));
        check("frame_end_irq_n", 32'(irq_n), irq_expect());
    endtask

    initial begin
        logic [7:0] r;
        logic [4:0] a;
        int         n;

        // Reset.
        reset_reset_n = 1'b0;
        spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1;
        loc_we = 1'b0; loc_addr = 5'd0; loc_wdata = 8'h00; loc_irq_set = 8'h00;
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        tick(3);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_irq_n", 32'(irq_n), 32'd1);
        check("rst_loc_rdata", 32'(loc_rdata), 32'd0);
        check("rst_wr_valid", 32'(spi_wr_valid), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        reset_reset_n = 1'b1;
        tick(4);

        // Write frame to HIEN.
        tx_q.push_back(8'h01);
        spi_frame(8'hD2, 1, 8'h00);
        loc_check("t1_hien", REG_HIEN);
        check("t1_hien_const", 32'(loc_rdata), 32'h01);

        // Read frame: status byte during command, register byte after.
        loc_write(5'd1, 8'h04);
        irq_pulse(8'h80);
        tx_q.push_back(8'h00);
        spi_frame(8'h08, 1, 8'h00);
        check("t2_rx_cmd", 32'(rx_q[0]), 32'h80);
        check("t2_rx_data", 32'(rx_q[1]), 32'h04);

        // Interrupt output latency and W1C clear from SPI.
        loc_write(REG_HIEN, 8'h40);
        tick(1);
        check("t3_irq_idle", 32'(irq_n), 32'd1);
        loc_irq_set = 8'h40;
        tick(1);
        loc_irq_set = 8'h00;
        model[REG_HIRQ] = model[REG_HIRQ] | 8'h40;
        check("t3_irq_not_yet", 32'(irq_n), 32'd1);
        tick(1);
        check("t3_irq_asserted", 32'(irq_n), 32'd0);
        tx_q.push_back(8'hC0);
        spi_frame(8'hCA, 1, 8'h00);
        loc_check("t3_hirq_cleared", REG_HIRQ);
        check("t3_irq_released", 32'(irq_n), 32'd1);

        // Local set on the W1C commit edge wins.
        irq_pulse(8'h40);
        tx_q.push_back(8'h40);
        spi_frame(8'hCA, 1, 8'h40);
        loc_check("t4_hirq_model", REG_HIRQ);
        check("t4_bit6_kept", 32'(loc_rdata), 32'h40);

        // Aborted partial byte commits nothing; next frame decodes.
        spi_ss_n = 1'b0;
        tick(H);
        spi_bits(8'h1A, 8, 8'h00, r);
        spi_bits(8'hA5, 5, 8'h00, r);
        tick(H);
        spi_ss_n = 1'b1;
        tick(2*H);
        compare_commits();
        check("t5_idle", 32'(fsm_state), 32'(IDLE));
        loc_check("t5_reg3_untouched", 5'd3);
        tx_q.push_back(8'h3C);
        spi_frame(8'h1A, 1, 8'h00);
        tx_q.push_back(8'h00);
        spi_frame(8'h18, 1, 8'h00);
        check("t5_readback", 32'(rx_q[1]), 32'h3C);

        // Multi-byte write stays on one address.
        tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
        spi_frame(8'h12, 3, 8'h00);
        loc_check("t6_reg2_last", REG_SNDFIFO);
        check("t6_reg2_const", 32'(loc_rdata), 32'h33);

        // Random traffic.
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    a = 5'($urandom_range(0, 31));
                    n = $urandom_range(1, 3);
                    for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
                    spi_frame({a, 1'($urandom), 1'b1, 1'($urandom)}, n, 8'h00);
                end
                1: begin
                    a = 5'($urandom_range(0, 31));
                    n = $urandom_range(1, 3);
                    for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
                    spi_frame({a, 1'($urandom), 1'b0, 1'($urandom)}, n, 8'h00);
                end
                2: loc_write(5'($urandom_range(0, 31)), 8'($urandom));
                default: irq_pulse(8'($urandom));
            endcase
        end
        tick(2);
        check("rand_irq_n", 32'(irq_n), irq_expect());
        for (int i = 0; i < 32; i++) loc_check("rand_reg_sweep", 5'(i));

        // Reset in the middle of a write frame.
        loc_addr = REG_SNDFIFO;
        spi_ss_n = 1'b0;
        tick(H);
        spi_bits(8'h12, 8, 8'h00, r);
        spi_bits(8'hFF, 4, 8'h00, r);
        reset_reset_n = 1'b0;
        #1;
        check("mid_rst_miso", 32'(spi_miso), 32'd0);
        check("mid_rst_irq_n", 32'(irq_n), 32'd1);
        check("mid_rst_loc_rdata", 32'(loc_rdata), 32'd0);
        check("mid_rst_wr_valid", 32'(spi_wr_valid), 32'd0);
        check("mid_rst_state", 32'(fsm_state), 32'(IDLE));
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        spi_ss_n = 1'b1; spi_sclk = 1'b0;
        tick(3);
        reset_reset_n = 1'b1;
        tick(4);
        compare_commits();
        loc_check("post_rst_reg2", REG_SNDFIFO);
        check("post_rst_state", 32'(fsm_state), 32'(IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
